// File: rtl/rf80386_bus_arbiter.sv
// Two-port FTA master arbiter: icache fill vs CPU data path, with a completion watchdog.
// Optional build macro RF80386_ARB_RR_EN selects round-robin tie-break (default: data wins ties).
package rf80386_fta_pkg;
  typedef struct packed {
    logic [5:0] core;
    logic [1:0] channel;
    logic [7:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    fta_tranid_t  tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         err;
    fta_tranid_t  tid;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;
endpackage

module rf80386_bus_arbiter
  import rf80386_fta_pkg::*;
#(
  parameter int         TIMEOUT = 255,
  parameter logic [5:0] CORENO  = 6'd1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  fta_cmd_request128_t  ireq_i,
  output fta_cmd_response128_t iresp_o,
  input  fta_cmd_request128_t  dreq_i,
  output fta_cmd_response128_t dresp_o,
  output fta_cmd_request128_t  ftam_req_o,
  input  fta_cmd_response128_t ftam_resp_i,
  output logic [1:0]           gnt_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

  localparam logic [9:0] TO = 10'(TIMEOUT);

  state_t               r_state, w_nxt;
  fta_cmd_request128_t  r_req, w_req_nxt, w_gnt_req;
  fta_cmd_response128_t w_resp;
  logic [9:0]           r_cnt, w_cnt_nxt;
  logic                 w_granted, w_live, w_done, w_wd, w_tie_d;

  function automatic fta_cmd_request128_t with_core(input fta_cmd_request128_t r);
    with_core          = r;
    with_core.tid.core = CORENO;
  endfunction

  function automatic fta_cmd_request128_t ctl_off(input fta_cmd_request128_t r);
    ctl_off     = r;
    ctl_off.cyc = 1'b0;
    ctl_off.stb = 1'b0;
    ctl_off.we  = 1'b0;
    ctl_off.sel = '0;
  endfunction

`ifdef RF80386_ARB_RR_EN
  logic r_last_d;
  assign w_tie_d = ~r_last_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         r_last_d <= 1'b0;
    else if (r_state == IDLE && w_nxt != IDLE) r_last_d <= (w_nxt == GNT_D);
  end
`else
  assign w_tie_d = 1'b1;
`endif

  assign w_gnt_req = (r_state == GNT_D) ? dreq_i : ireq_i;
  assign w_granted = (r_state == GNT_I) || (r_state == GNT_D);
  // A requester that has dropped cyc gets no response even if the bus answers.
  assign w_live    = w_granted && w_gnt_req.cyc;
  assign w_done    = ftam_resp_i.ack | ftam_resp_i.rty;
  assign w_wd      = w_live && !w_done && (r_cnt == TO);

  always_comb begin
    w_nxt     = r_state;
    w_req_nxt = r_req;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (dreq_i.cyc && (!ireq_i.cyc || w_tie_d)) begin
          w_nxt     = GNT_D;
          w_req_nxt = with_core(dreq_i);
          w_cnt_nxt = '0;
        end else if (ireq_i.cyc) begin
          w_nxt     = GNT_I;
          w_req_nxt = with_core(ireq_i);
          w_cnt_nxt = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!w_live || w_done || w_wd) begin
          w_nxt     = RELEASE;
          w_req_nxt = ctl_off(r_req);
          w_cnt_nxt = '0;
        end else begin
          w_req_nxt = with_core(w_gnt_req);
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      RELEASE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_req             <= '0;
      r_req.tid.core    <= CORENO;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  always_comb begin
    w_resp = ftam_resp_i;
    if (w_wd) w_resp.rty = 1'b1;
  end

  assign iresp_o    = (w_live && r_state == GNT_I) ? w_resp : '0;
  assign dresp_o    = (w_live && r_state == GNT_D) ? w_resp : '0;
  assign ftam_req_o = r_req;
  assign gnt_o      = {r_state == GNT_D, r_state == GNT_I};
  assign timeout_o  = w_wd;

endmodule

// File: tb/tb_rf80386_bus_arbiter.sv
// Bench for rf80386_bus_arbiter: directed vector table, corner sequences, randomized model check.
module tb_rf80386_bus_arbiter;
  import rf80386_fta_pkg::*;

  localparam int TO = 8;
`ifdef RF80386_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  fta_cmd_request128_t  ireq, dreq, ftam_req;
  fta_cmd_response128_t iresp, dresp, bus;
  logic [1:0] gnt;
  logic       tmo;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rf80386_bus_arbiter #(.TIMEOUT(TO), .CORENO(6'd1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ireq_i(ireq), .iresp_o(iresp),
    .dreq_i(dreq), .dresp_o(dresp),
    .ftam_req_o(ftam_req), .ftam_resp_i(bus),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  typedef struct {
    bit rst, i, d, ack, rty;
    logic [1:0] gnt;
    bit fcyc, iack, irty, dack, drty, tmo;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic fta_cmd_request128_t rst_req();
    rst_req = '0;
    rst_req.tid.core = 6'd1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    ireq = '0; dreq = '0; bus = '0;
    ireq.adr = 32'h0000_2000;
    dreq.adr = 32'h0000_1000;
    @(negedge clk);
    #1;
    chk("rst_ftam", 200'(ftam_req), 200'(rst_req()));
    chk("rst_gnt_tmo", {gnt, tmo}, 3'b000);
    chk("rst_resp", 200'({iresp.ack, iresp.rty, dresp.ack, dresp.rty}), 200'(0));
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Reference model: who owns the bus, how long it has waited, and whether the dead cycle is due.
  int m_own, m_wait, m_last;
  bit m_dead;
  fta_cmd_request128_t  m_bus;

  task automatic model_reset();
    m_own = 0; m_wait = 0; m_last = 1; m_dead = 0;
    m_bus = rst_req();
  endtask

  task automatic model_check();
    fta_cmd_request128_t  r;
    fta_cmd_response128_t er, ei, ed;
    bit live, t;
    r    = (m_own == 2) ? dreq : ireq;
    live = (m_own != 0) && r.cyc;
    t    = live && !bus.ack && !bus.rty && (m_wait == TO);
    er   = live ? bus : '0;
    if (t) er.rty = 1'b1;
    ei = (m_own == 1) ? er : '0;
    ed = (m_own == 2) ? er : '0;
    chk("rnd_gnt", 200'(gnt), 200'((m_own == 2) ? 2 : (m_own == 1) ? 1 : 0));
    chk("rnd_tmo", 200'(tmo), 200'(t));
    chk("rnd_iresp", 200'(iresp), 200'(ei));
    chk("rnd_dresp", 200'(dresp), 200'(ed));
    chk("rnd_ftam", 200'(ftam_req), 200'(m_bus));
  endtask

  task automatic model_step();
    fta_cmd_request128_t r;
    int pick;
    r = (m_own == 2) ? dreq : ireq;
    if (m_dead) m_dead = 0;
    else if (m_own == 0) begin
      pick = 0;
      if (ireq.cyc && dreq.cyc) pick = RR ? ((m_last == 2) ? 1 : 2) : 2;
      else if (dreq.cyc) pick = 2;
      else if (ireq.cyc) pick = 1;
      if (pick != 0) begin
        m_own = pick; m_last = pick; m_wait = 0;
        m_bus = (pick == 2) ? dreq : ireq;
        m_bus.tid.core = 6'd1;
      end
    end else if (!r.cyc || bus.ack || bus.rty || m_wait == TO) begin
      m_own = 0; m_dead = 1; m_wait = 0;
      m_bus.cyc = 0; m_bus.stb = 0; m_bus.we = 0; m_bus.sel = '0;
    end else begin
      m_wait++;
      m_bus = r;
      m_bus.tid.core = 6'd1;
    end
  endtask

  task automatic rnd_req(inout fta_cmd_request128_t q);
    if (q.cyc) begin
      if ($urandom_range(9) == 0) q.cyc = 1'b0;
    end else if ($urandom_range(3) == 0) begin
      q.cyc = 1'b1;
      q.adr = $urandom;
    end
    q.stb = q.cyc & $urandom_range(1);
    q.we  = $urandom_range(1);
    q.sel = 16'($urandom);
    q.dat = {$urandom, $urandom, $urandom, $urandom};
    q.tid = 16'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ireq = '0; dreq = '0; bus = '0;
    // rst i d ack rty gnt fcyc iack irty dack drty tmo
    tbl[0]  = '{1,0,1,0,0,2'b00,0,0,0,0,0,0};
    tbl[1]  = '{0,0,1,0,0,2'b10,1,0,0,0,0,0};
    tbl[2]  = '{0,0,1,0,0,2'b10,1,0,0,0,0,0};
    tbl[3]  = '{0,0,1,1,0,2'b10,1,0,0,1,0,0};
    tbl[4]  = '{0,0,0,1,0,2'b00,0,0,0,0,0,0};
    tbl[5]  = '{0,0,0,0,0,2'b00,0,0,0,0,0,0};
    tbl[6]  = '{1,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[7]  = '{0,1,1,1,0,2'b10,1,0,0,1,0,0};
    tbl[8]  = '{0,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[9]  = '{0,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[10] = RR ? '{0,1,1,1,0,2'b01,1,1,0,0,0,0} : '{0,1,1,1,0,2'b10,1,0,0,1,0,0};
    tbl[11] = '{0,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[12] = '{0,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[13] = '{0,1,1,1,0,2'b10,1,0,0,1,0,0};
    tbl[14] = '{0,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[15] = '{0,1,1,1,0,2'b00,0,0,0,0,0,0};
    tbl[16] = RR ? '{0,1,1,1,0,2'b01,1,1,0,0,0,0} : '{0,1,1,1,0,2'b10,1,0,0,1,0,0};

    for (int n = 0; n < 17; n++) begin
      if (tbl[n].rst) do_reset();
      @(negedge clk);
      ireq.cyc = tbl[n].i; dreq.cyc = tbl[n].d;
      bus.ack = tbl[n].ack; bus.rty = tbl[n].rty;
      #1;
      chk($sformatf("tbl%0d_gnt", n), 200'(gnt), 200'(tbl[n].gnt));
      chk($sformatf("tbl%0d_ctl", n),
          200'({ftam_req.cyc, iresp.ack, iresp.rty, dresp.ack, dresp.rty, tmo}),
          200'({tbl[n].fcyc, tbl[n].iack, tbl[n].irty, tbl[n].dack, tbl[n].drty, tbl[n].tmo}));
      if (n == 1) chk("tbl1_adr", 200'(ftam_req.adr), 200'(32'h0000_1000));
    end

    // Watchdog abort, then ack landing on the timeout cycle.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      @(negedge clk);
      ireq.cyc = 1'b1;
      #1 chk("wd_idle_gnt", 200'(gnt), 200'(0));
      for (int k = 1; k <= 11; k++) begin
        @(negedge clk);
        if (k == 9 && pass == 1) bus.ack = 1'b1;
        if (k == 10) bus.ack = 1'b0;
        if (k == 11) ireq.cyc = 1'b0;
        #1;
        if (k == 1) chk("wd_grant", 200'({gnt, ftam_req.cyc}), 200'({2'b01, 1'b1}));
        if (k < 9) chk($sformatf("wd_wait%0d", k), 200'({tmo, iresp.rty, iresp.ack}), 200'(0));
        if (k == 9 && pass == 0) chk("wd_fire", 200'({tmo, iresp.rty, iresp.ack}), 200'(3'b110));
        if (k == 9 && pass == 1) chk("wd_ackwin", 200'({tmo, iresp.rty, iresp.ack}), 200'(3'b001));
        if (k == 10) chk("wd_release", 200'({gnt, ftam_req.cyc, tmo, iresp.rty}), 200'(0));
        if (k == 11) chk("wd_idle", 200'({gnt, ftam_req.cyc}), 200'(0));
      end
    end

    // Asynchronous reset in the middle of a data grant.
    do_reset();
    @(negedge clk); dreq.cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("ar_pre_gnt", 200'(gnt), 200'(2'b10));
    bus.ack = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_ctl", 200'({ftam_req.cyc, gnt}), 200'(0));
    chk("ar_dresp", 200'(dresp), 200'(0));
    chk("ar_iresp", 200'(iresp), 200'(0));
    bus.ack = 1'b0; dreq.cyc = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; ireq.cyc = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_regrant", 200'({gnt, ftam_req.cyc}), 200'({2'b01, 1'b1}));
    chk("ar_adr", 200'({ftam_req.adr, ftam_req.tid.core}), 200'({32'h0000_2000, 6'd1}));

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rnd_req(ireq);
      rnd_req(dreq);
      bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.ack = ($urandom_range(5) == 0);
      bus.rty = ($urandom_range(24) == 0);
      #1 model_check();
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
